// File: rtl/axi2mem_bridge.sv
// AXI4 slave to dual-port SRAM bridge with parameterised widths, read latency and
// read-return buffering; supports FIXED/INCR/WRAP bursts and OKAY/SLVERR responses.
module axi2mem_bridge #(
  parameter int unsigned DATA_W     = 512,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned ID_W       = 7,
  parameter int unsigned MEM_RD_LAT = 1,
  parameter int unsigned RBUF_DEPTH = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  // AW channel
  input  logic [ADDR_W-1:0]     s_awaddr,
  input  logic [ID_W-1:0]       s_awid,
  input  logic [7:0]            s_awlen,
  input  logic [2:0]            s_awsize,
  input  logic [1:0]            s_awburst,
  input  logic                  s_awvalid,
  output logic                  s_awready,
  // W channel
  input  logic [DATA_W-1:0]     s_wdata,
  input  logic [DATA_W/8-1:0]   s_wstrb,
  input  logic                  s_wlast,
  input  logic                  s_wvalid,
  output logic                  s_wready,
  // B channel
  output logic [ID_W-1:0]       s_bid,
  output logic [1:0]            s_bresp,
  output logic                  s_bvalid,
  input  logic                  s_bready,
  // AR channel
  input  logic [ADDR_W-1:0]     s_araddr,
  input  logic [ID_W-1:0]       s_arid,
  input  logic [7:0]            s_arlen,
  input  logic [2:0]            s_arsize,
  input  logic [1:0]            s_arburst,
  input  logic                  s_arvalid,
  output logic                  s_arready,
  // R channel
  output logic [DATA_W-1:0]     s_rdata,
  output logic [ID_W-1:0]       s_rid,
  output logic [1:0]            s_rresp,
  output logic                  s_rlast,
  output logic                  s_rvalid,
  input  logic                  s_rready,
  // memory write port
  output logic                  mem_wr_en,
  output logic [DATA_W/8-1:0]   mem_wstrb,
  output logic [ADDR_W-1:0]     mem_waddr,
  output logic [DATA_W-1:0]     mem_wdata,
  // memory read port
  output logic                  mem_rd_en,
  output logic [ADDR_W-1:0]     mem_raddr,
  input  logic [DATA_W-1:0]     mem_rdata
);

  localparam int unsigned STRB_W   = DATA_W / 8;
  localparam int unsigned MAX_SIZE = $clog2(STRB_W);
  localparam int unsigned PTR_W    = $clog2(RBUF_DEPTH);
  localparam int unsigned CNT_W    = PTR_W + 1;
  localparam int unsigned INF_W    = $clog2(MEM_RD_LAT + 1);
  localparam int unsigned OCC_W    = 8;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] W_IDLE  = 2'd0;
  localparam logic [1:0] W_DATA  = 2'd1;
  localparam logic [1:0] W_RESP  = 2'd2;
  localparam logic [0:0] R_IDLE  = 1'b0;
  localparam logic [0:0] R_ISSUE = 1'b1;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic            last;
    logic            err;
    logic            zero;
  } rtag_t;

  function automatic logic legal_wrap_len(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

  function automatic logic is_oversize(input logic [2:0] size);
    return 32'(size) > MAX_SIZE;
  endfunction

  function automatic logic cfg_err(input logic [7:0] len, input logic [2:0] size,
                                   input logic [1:0] burst);
    return ((burst == BURST_WRAP) && !legal_wrap_len(len)) || is_oversize(size);
  endfunction

  // Address of the following beat; illegal-length WRAP falls through to INCR.
  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] addr,
                                                  input logic [7:0]        len,
                                                  input logic [2:0]        size,
                                                  input logic [1:0]        burst);
    logic [ADDR_W-1:0] step, aligned, inc, wsize, base, nxt;
    step    = ADDR_W'(1) << size;
    aligned = addr & ~(step - ADDR_W'(1));
    inc     = aligned + step;
    wsize   = (ADDR_W'(len) + ADDR_W'(1)) << size;
    base    = aligned & ~(wsize - ADDR_W'(1));
    nxt     = inc;
    if (burst == BURST_FIXED)
      nxt = addr;
    else if ((burst == BURST_WRAP) && legal_wrap_len(len) && (inc == base + wsize))
      nxt = base;
    return nxt;
  endfunction

  // ---------------------------------------------------------------- write path
  logic [1:0]        w_state, w_state_nxt;
  logic [ADDR_W-1:0] w_addr;
  logic [ID_W-1:0]   w_id;
  logic [7:0]        w_len, w_cnt;
  logic [2:0]        w_size;
  logic [1:0]        w_burst;
  logic              w_err, w_oversize;
  logic              aw_fire, w_fire, w_last_beat;

  assign s_awready   = (w_state == W_IDLE);
  assign s_wready    = (w_state == W_DATA);
  assign s_bvalid    = (w_state == W_RESP);
  assign aw_fire     = s_awvalid && s_awready;
  assign w_fire      = s_wvalid && s_wready;
  assign w_last_beat = (w_cnt == w_len);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) w_state <= W_IDLE;
    else       w_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = w_state;
    case (w_state)
      W_IDLE:  if (aw_fire)                w_state_nxt = W_DATA;
      W_DATA:  if (w_fire && w_last_beat)  w_state_nxt = W_RESP;
      W_RESP:  if (s_bready)               w_state_nxt = W_IDLE;
      default:                             w_state_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      w_addr     <= '0;
      w_id       <= '0;
      w_len      <= '0;
      w_size     <= '0;
      w_burst    <= '0;
      w_cnt      <= '0;
      w_err      <= 1'b0;
      w_oversize <= 1'b0;
    end else if (aw_fire) begin
      w_addr     <= s_awaddr;
      w_id       <= s_awid;
      w_len      <= s_awlen;
      w_size     <= s_awsize;
      w_burst    <= s_awburst;
      w_cnt      <= '0;
      w_err      <= cfg_err(s_awlen, s_awsize, s_awburst);
      w_oversize <= is_oversize(s_awsize);
    end else if (w_fire) begin
      w_cnt  <= w_cnt + 8'd1;
      w_addr <= next_addr(w_addr, w_len, w_size, w_burst);
      if (s_wlast != w_last_beat) w_err <= 1'b1;
    end
  end

  assign s_bid     = s_bvalid ? w_id : '0;
  assign s_bresp   = (s_bvalid && w_err) ? RESP_SLVERR : RESP_OKAY;

  // Oversize beats complete the handshake but never touch memory.
  assign mem_wr_en = w_fire && !w_oversize;
  assign mem_waddr = mem_wr_en ? w_addr  : '0;
  assign mem_wdata = mem_wr_en ? s_wdata : '0;
  assign mem_wstrb = mem_wr_en ? s_wstrb : '0;

  // ----------------------------------------------------------------- read path
  logic [0:0]        r_state, r_state_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic [ID_W-1:0]   r_id;
  logic [7:0]        r_len, r_cnt;
  logic [2:0]        r_size;
  logic [1:0]        r_burst;
  logic              r_err, r_oversize;
  logic              ar_fire, rd_issue, credit;

  logic [MEM_RD_LAT-1:0] pipe_vld;
  rtag_t                 pipe_tag [MEM_RD_LAT];
  rtag_t                 issue_tag;
  logic [INF_W-1:0]      inflight;
  logic [OCC_W-1:0]      occupancy;

  logic [DATA_W-1:0]     fifo_data [RBUF_DEPTH];
  rtag_t                 fifo_tag  [RBUF_DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [CNT_W-1:0]      fifo_count;
  logic                  push, pop;
  rtag_t                 head_tag;

  assign s_arready = (r_state == R_IDLE);
  assign ar_fire   = s_arvalid && s_arready;

  // Beats in the memory pipe plus buffered beats never exceed the FIFO size.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < MEM_RD_LAT; i++) inflight = inflight + INF_W'(pipe_vld[i]);
  end
  assign occupancy = OCC_W'(fifo_count) + OCC_W'(inflight);
  assign credit    = occupancy < OCC_W'(RBUF_DEPTH);
  assign rd_issue  = (r_state == R_ISSUE) && credit;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= R_IDLE;
    else       r_state <= r_state_nxt;
  end

  always_comb begin
    r_state_nxt = r_state;
    case (r_state)
      R_IDLE:  if (ar_fire)                      r_state_nxt = R_ISSUE;
      R_ISSUE: if (rd_issue && (r_cnt == r_len)) r_state_nxt = R_IDLE;
      default:                                   r_state_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_addr     <= '0;
      r_id       <= '0;
      r_len      <= '0;
      r_size     <= '0;
      r_burst    <= '0;
      r_cnt      <= '0;
      r_err      <= 1'b0;
      r_oversize <= 1'b0;
    end else if (ar_fire) begin
      r_addr     <= s_araddr;
      r_id       <= s_arid;
      r_len      <= s_arlen;
      r_size     <= s_arsize;
      r_burst    <= s_arburst;
      r_cnt      <= '0;
      r_err      <= cfg_err(s_arlen, s_arsize, s_arburst);
      r_oversize <= is_oversize(s_arsize);
    end else if (rd_issue) begin
      r_cnt  <= r_cnt + 8'd1;
      r_addr <= next_addr(r_addr, r_len, r_size, r_burst);
    end
  end

  assign mem_rd_en = rd_issue && !r_oversize;
  assign mem_raddr = mem_rd_en ? r_addr : '0;

  always_comb begin
    issue_tag      = '0;
    issue_tag.id   = r_id;
    issue_tag.last = (r_cnt == r_len);
    issue_tag.err  = r_err;
    issue_tag.zero = r_oversize;
  end

  // Beat tags travel alongside the memory access and meet mem_rdata on arrival.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pipe_vld <= '0;
      for (int i = 0; i < MEM_RD_LAT; i++) pipe_tag[i] <= '0;
    end else begin
      pipe_vld[0] <= rd_issue;
      pipe_tag[0] <= issue_tag;
      for (int i = 1; i < MEM_RD_LAT; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        pipe_tag[i] <= pipe_tag[i-1];
      end
    end
  end

  assign push = pipe_vld[MEM_RD_LAT-1];
  assign pop  = s_rvalid && s_rready;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_data[wr_ptr] <= pipe_tag[MEM_RD_LAT-1].zero ? '0 : mem_rdata;
      fifo_tag[wr_ptr]  <= pipe_tag[MEM_RD_LAT-1];
    end
  end

  assign s_rvalid = (fifo_count != '0);
  assign head_tag = s_rvalid ? fifo_tag[rd_ptr] : '0;
  assign s_rdata  = s_rvalid ? fifo_data[rd_ptr] : '0;
  assign s_rid    = head_tag.id;
  assign s_rlast  = head_tag.last;
  assign s_rresp  = head_tag.err ? RESP_SLVERR : RESP_OKAY;

endmodule
